// File: rtl/histogram_stream_if.sv
// Pixel-in / histogram-out handshake bundle for histogram_stream.
// The slave modport is the block's view; the master modport is the driver's view.
interface histogram_stream_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 24
);
    logic                   start_i;
    logic                   pix_valid_i;
    logic [PIX_W-1:0]       pix_i;
    logic                   pix_ready_o;
    logic                   rd_valid_o;
    logic                   rd_ready_i;
    logic [PIX_W+CNT_W-1:0] rd_data_o;
    logic                   busy_o;
    logic                   done_o;

    modport slave (
        input  start_i, pix_valid_i, pix_i, rd_ready_i,
        output pix_ready_o, rd_valid_o, rd_data_o, busy_o, done_o
    );

    modport master (
        output start_i, pix_valid_i, pix_i, rd_ready_i,
        input  pix_ready_o, rd_valid_o, rd_data_o, busy_o, done_o
    );
endinterface

// File: rtl/histogram_stream.sv
// Streaming frame histogram: clears NB bins, counts one pixel per cycle into
// saturating bins through a registered-read RMW pipeline, then drains bins in order.
module histogram_stream #(
    parameter int PIX_W   = 8,
    parameter int CNT_W   = 24,
    parameter int NUM_PIX = 76800
) (
    input  logic clk_i,
    input  logic rst_i,
    histogram_stream_if.slave bus
);
    localparam int NB   = 1 << PIX_W;
    localparam int PC_W = $clog2(NUM_PIX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PC_W-1:0]  LAST_PIX = PC_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] mem [NB];

    logic [PIX_W-1:0] bin_idx, bin_idx_next;
    logic [PC_W-1:0]  pix_cnt, pix_cnt_next;
    logic             rd_valid, rd_valid_next;
    logic             done, done_next;
    logic             accept;
    logic             xfer;

    logic             vld_p0, vld_p1, vld_p2;
    logic [PIX_W-1:0] idx_p0, idx_p1, idx_p2;
    logic [CNT_W-1:0] rdq_p1, old_p1, new_p1, cnt_p2;

    logic [PIX_W-1:0] rd_addr, wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic             wr_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_comb begin
        state_next    = state;
        bin_idx_next  = bin_idx;
        pix_cnt_next  = pix_cnt;
        rd_valid_next = rd_valid;
        done_next     = 1'b0;
        accept        = 1'b0;
        xfer          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_next   = CLEAR;
                    bin_idx_next = '0;
                    pix_cnt_next = '0;
                end
            end
            CLEAR: begin
                bin_idx_next = bin_idx + 1'b1;
                if (bin_idx == '1) state_next = ACCUM;
            end
            ACCUM: begin
                accept = bus.pix_valid_i;
                if (accept) begin
                    pix_cnt_next = pix_cnt + 1'b1;
                    if (pix_cnt == LAST_PIX) state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The p1 write lands on the edge that enters DRAIN, and the
                // first drain read happens one cycle later, so only p0 matters.
                if (!vld_p0) begin
                    state_next    = DRAIN;
                    bin_idx_next  = '0;
                    rd_valid_next = 1'b0;
                end
            end
            DRAIN: begin
                xfer = rd_valid && bus.rd_ready_i;
                if (!rd_valid) begin
                    rd_valid_next = 1'b1;
                end else if (xfer) begin
                    if (bin_idx == '1) begin
                        rd_valid_next = 1'b0;
                        done_next     = 1'b1;
                        state_next    = IDLE;
                        bin_idx_next  = '0;
                    end else begin
                        bin_idx_next = bin_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            bin_idx  <= '0;
            pix_cnt  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bin_idx  <= bin_idx_next;
            pix_cnt  <= pix_cnt_next;
            rd_valid <= rd_valid_next;
            done     <= done_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Single registered read port: pipeline lookups while counting, the
    // presented bin while draining (re-read each cycle, so a stall holds it).
    assign rd_addr = (state == DRAIN) ? bin_idx_next : idx_p0;

    // p0 -> p1: bin lookup issued with the accepted pixel index
    always_ff @(posedge clk_i) begin
        idx_p0 <= bus.pix_i;
        idx_p1 <= idx_p0;
        rdq_p1 <= mem[rd_addr];
    end

    // p1: the read above raced the write of the previous pixel; forward it
    assign old_p1 = (vld_p2 && (idx_p2 == idx_p1)) ? cnt_p2 : rdq_p1;
    assign new_p1 = sat_inc(old_p1);

    assign wr_en   = (state == CLEAR) || vld_p1;
    assign wr_addr = (state == CLEAR) ? bin_idx : idx_p1;
    assign wr_data = (state == CLEAR) ? '0 : new_p1;

    // p1 -> p2: commit and remember the committed value for forwarding
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        idx_p2 <= idx_p1;
        cnt_p2 <= new_p1;
    end

    assign bus.pix_ready_o = (state == ACCUM);
    assign bus.rd_valid_o  = rd_valid;
    assign bus.rd_data_o   = rd_valid ? {bin_idx, rdq_p1} : '0;
    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = done;
endmodule

// File: tb/tb_histogram_stream.sv
// Bench for histogram_stream: small configuration (2-bit pixels, 3-bit bins,
// 8-pixel frames) against a counting model, plus one full default-size frame.
module tb_histogram_stream;
    localparam int PW  = 2;
    localparam int CW  = 3;
    localparam int NP  = 8;
    localparam int NB  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    histogram_stream_if #(.PIX_W(PW), .CNT_W(CW)) sb ();
    histogram_stream #(.PIX_W(PW), .CNT_W(CW), .NUM_PIX(NP)) dut_s (
        .clk_i(clk), .rst_i(rst), .bus(sb.slave));

    histogram_stream_if #(.PIX_W(8), .CNT_W(24)) bb ();
    histogram_stream dut_b (.clk_i(clk), .rst_i(rst), .bus(bb.slave));

    int checks = 0;
    int errors = 0;

    int px [NP];
    int exp_cnt [NB];
    int got_idx [$];
    int got_cnt [$];
    int n_acc, done_cnt, hold_err, timeout;
    logic ready_after_last, busy_after_done;

    // Histogram from the definition: occurrences per bin, clipped at the max count.
    task automatic model_hist();
        for (int b = 0; b < NB; b++) begin
            int n = 0;
            for (int i = 0; i < NP; i++) if (px[i] == b) n++;
            exp_cnt[b] = (n > MAXC) ? MAXC : n;
        end
    endtask

    // vmode: 0 continuous, 1 toggling, 2 random. rmode: 0 always ready,
    // 1 random, 2 three-cycle stall when bin 1 first appears.
    task automatic do_frame(input int vmode, input int rmode, input bit rand_start);
        int k, cyc, quiet, post, stall_left;
        bit v, acc, r, stalled_prev, stall_done;
        logic [PW+CW-1:0] prev_data;
        got_idx.delete(); got_cnt.delete();
        n_acc = 0; done_cnt = 0; hold_err = 0; timeout = 0;
        ready_after_last = 1'b1; busy_after_done = 1'b1;
        @(posedge clk); #1; sb.start_i = 1'b1;
        @(posedge clk); #1; sb.start_i = 1'b0;
        cyc = 0;
        while (!sb.pix_ready_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (!sb.pix_ready_o) timeout = 1;
        k = 0; cyc = 0; quiet = 0;
        while (quiet < 3 && cyc < 100) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            sb.pix_valid_i = v;
            sb.pix_i = (k < NP) ? PW'(px[k]) : PW'((px[NP-1] + 1) % NB);
            sb.start_i = rand_start && sb.pix_ready_o && ($urandom_range(0, 1) == 1);
            acc = v && sb.pix_ready_o;
            @(posedge clk); #1; cyc++;
            if (acc) begin
                n_acc++; k++;
                if (n_acc == NP) ready_after_last = sb.pix_ready_o;
            end
            if (k >= NP) quiet++;
        end
        if (n_acc < NP) timeout = 1;
        sb.pix_valid_i = 1'b0; sb.start_i = 1'b0;
        cyc = 0; post = 0; stall_left = 0; stall_done = 0; stalled_prev = 0; prev_data = '0;
        while (cyc < 200 && post < 4) begin
            if (stalled_prev && (!sb.rd_valid_o || sb.rd_data_o !== prev_data)) hold_err++;
            if (sb.done_o) begin
                done_cnt++;
                busy_after_done = sb.busy_o;
                if (sb.rd_valid_o) hold_err++;
            end
            if (rmode == 0) r = 1'b1;
            else if (rmode == 1) r = 1'($urandom_range(0, 1));
            else begin
                if (sb.rd_valid_o && sb.rd_data_o[PW+CW-1:CW] == 1 && !stall_done) begin
                    stall_left = 3; stall_done = 1;
                end
                r = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            sb.rd_ready_i = r;
            sb.start_i = rand_start && sb.rd_valid_o && ($urandom_range(0, 1) == 1);
            if (sb.rd_valid_o && r) begin
                got_idx.push_back(int'(sb.rd_data_o[PW+CW-1:CW]));
                got_cnt.push_back(int'(sb.rd_data_o[CW-1:0]));
            end
            stalled_prev = sb.rd_valid_o && !r;
            prev_data = sb.rd_data_o;
            if (done_cnt > 0) post++;
            @(posedge clk); #1; cyc++;
        end
        sb.start_i = 1'b0; sb.rd_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sb.pix_ready_o !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b expected 0", sb.pix_ready_o); end
        checks++; if (sb.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", sb.rd_valid_o); end
        checks++; if (sb.rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", sb.rd_data_o); end
        checks++; if (sb.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sb.busy_o); end
        checks++; if (sb.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sb.done_o); end
        checks++; if (bb.busy_o !== 1'b0 || bb.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_big: got busy %b rd_valid %b expected 0 0", bb.busy_o, bb.rd_valid_o); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int exp_d [NB] = '{1, 2, 1, 4};
        px = '{0, 1, 1, 2, 3, 3, 3, 3};
        do_frame(0, 0, 0);
        checks++; if (got_idx.size() != NB) begin errors++; $display("FAIL directed_beats: got %0d expected %0d", got_idx.size(), NB); end
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_d[b]) begin
                errors++; $display("FAIL directed_bin%0d: got cnt %0d expected {%0d,%0d}", b, (b < got_cnt.size()) ? got_cnt[b] : -1, b, exp_d[b]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL directed_done: got %0d pulses expected 1", done_cnt); end
        checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL directed_busy_at_done: got %b expected 0", busy_after_done); end
        checks++; if (timeout != 0) begin errors++; $display("FAIL directed_timeout: got %0d expected 0", timeout); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < NP; i++) px[i] = 2;
        model_hist();
        do_frame(0, 0, 0);
        checks++; if (exp_cnt[2] != MAXC) begin errors++; $display("FAIL saturate_model: got %0d expected %0d", exp_cnt[2], MAXC); end
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_cnt[b]) begin
                errors++; $display("FAIL saturate_bin%0d: got cnt %0d expected %0d", b, (b < got_cnt.size()) ? got_cnt[b] : -1, exp_cnt[b]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL saturate_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_toggle_valid();
        for (int i = 0; i < NP; i++) px[i] = 1;
        model_hist();
        do_frame(1, 0, 0);
        checks++; if (n_acc != NP) begin errors++; $display("FAIL toggle_accepts: got %0d expected %0d", n_acc, NP); end
        checks++; if (ready_after_last !== 1'b0) begin errors++; $display("FAIL toggle_ready_drop: got %b expected 0", ready_after_last); end
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_cnt[b]) begin
                errors++; $display("FAIL toggle_bin%0d: got cnt %0d expected %0d", b, (b < got_cnt.size()) ? got_cnt[b] : -1, exp_cnt[b]);
            end
        end
    endtask

    task automatic test_rd_stall();
        for (int i = 0; i < NP; i++) px[i] = $urandom_range(0, NB - 1);
        px[0] = 1;
        model_hist();
        do_frame(0, 2, 0);
        checks++; if (hold_err != 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", hold_err); end
        checks++; if (got_idx.size() != NB) begin errors++; $display("FAIL stall_beats: got %0d expected %0d", got_idx.size(), NB); end
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_cnt[b]) begin
                errors++; $display("FAIL stall_bin%0d: got cnt %0d expected %0d", b, (b < got_cnt.size()) ? got_cnt[b] : -1, exp_cnt[b]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt, cyc, dn;
        bit acc;
        @(posedge clk); #1; sb.start_i = 1'b1;
        @(posedge clk); #1; sb.start_i = 1'b0;
        cyc = 0;
        while (!sb.pix_ready_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
        cnt = 0; cyc = 0; sb.pix_valid_i = 1'b1;
        while (cnt < 4 && cyc < 50) begin
            sb.pix_i = PW'($urandom_range(0, NB - 1));
            acc = sb.pix_ready_o;
            @(posedge clk); #1; cyc++;
            if (acc) cnt++;
        end
        sb.start_i = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({sb.pix_ready_o, sb.rd_valid_o, sb.busy_o, sb.done_o} !== 4'b0) begin errors++; $display("FAIL midreset_ctrl: got %b expected 0000", {sb.pix_ready_o, sb.rd_valid_o, sb.busy_o, sb.done_o}); end
        checks++; if (sb.rd_data_o !== '0) begin errors++; $display("FAIL midreset_data: got %0h expected 0", sb.rd_data_o); end
        rst = 1'b0; sb.start_i = 1'b0; sb.pix_valid_i = 1'b0;
        dn = 0;
        repeat (5) begin @(posedge clk); #1; if (sb.done_o || sb.busy_o) dn++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", dn); end
        for (int i = 0; i < NP; i++) px[i] = 0;
        model_hist();
        do_frame(0, 0, 0);
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_cnt[b]) begin
                errors++; $display("FAIL midreset_bin%0d: got cnt %0d expected %0d", b, (b < got_cnt.size()) ? got_cnt[b] : -1, exp_cnt[b]);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NP; i++) px[i] = $urandom_range(0, NB - 1);
            model_hist();
            do_frame(2, 1, 1);
            bad = 0;
            for (int b = 0; b < NB; b++)
                if (b >= got_idx.size() || got_idx[b] != b || got_cnt[b] != exp_cnt[b]) bad++;
            checks++; if (bad != 0 || got_idx.size() != NB) begin errors++; $display("FAIL random_frame%0d: got %0d bad of %0d beats expected 0 bad of %0d", f, bad, got_idx.size(), NB); end
            checks++; if (done_cnt != 1 || hold_err != 0 || timeout != 0) begin errors++; $display("FAIL random_ctrl%0d: got done %0d hold %0d timeout %0d expected 1 0 0", f, done_cnt, hold_err, timeout); end
        end
    endtask

    task automatic test_full_frame();
        int cyc, acc, beats, dn;
        bb.rd_ready_i = 1'b1; bb.pix_i = 8'hFF;
        @(posedge clk); #1; bb.start_i = 1'b1;
        @(posedge clk); #1; bb.start_i = 1'b0;
        cyc = 0;
        while (!bb.pix_ready_o && cyc < 400) begin @(posedge clk); #1; cyc++; end
        acc = 0; cyc = 0; bb.pix_valid_i = 1'b1;
        while (acc < 76800 && cyc < 80000) begin
            if (bb.pix_ready_o) acc++;
            @(posedge clk); #1; cyc++;
        end
        checks++; if (bb.pix_ready_o !== 1'b0 || acc != 76800) begin errors++; $display("FAIL full_accept: got %0d accepts ready %b expected 76800 ready 0", acc, bb.pix_ready_o); end
        bb.pix_valid_i = 1'b0;
        cyc = 0; beats = 0; dn = 0;
        while (cyc < 1000 && dn == 0) begin
            if (bb.done_o) dn++;
            if (bb.rd_valid_o) begin
                checks++;
                if (int'(bb.rd_data_o[31:24]) != beats || int'(bb.rd_data_o[23:0]) != ((beats == 255) ? 76800 : 0)) begin
                    errors++; $display("FAIL full_beat%0d: got {%0d,%0d} expected {%0d,%0d}", beats, bb.rd_data_o[31:24], bb.rd_data_o[23:0], beats, (beats == 255) ? 76800 : 0);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (beats != 256 || dn != 1) begin errors++; $display("FAIL full_readout: got %0d beats done %0d expected 256 beats done 1", beats, dn); end
    endtask

    initial begin
        rst = 1'b1;
        sb.start_i = 1'b0; sb.pix_valid_i = 1'b0; sb.pix_i = '0; sb.rd_ready_i = 1'b1;
        bb.start_i = 1'b0; bb.pix_valid_i = 1'b0; bb.pix_i = '0; bb.rd_ready_i = 1'b1;
        test_reset();
        test_directed();
        test_saturate();
        test_toggle_valid();
        test_rd_stall();
        test_reset_mid();
        test_random();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/histogram_stream.md
HISTOGRAM_STREAM -- requirements
Module: histogram_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width; bin count NB = 2^PIX_W.
REQ-002 SHALL have parameter CNT_W, default 24, per-bin counter width.
REQ-003 SHALL have parameter NUM_PIX, default 76800, pixels per frame.
REQ-004 SHALL have port clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  in  1  frame start request.
REQ-007 SHALL have port pix_valid_i  in  1  pixel beat valid.
REQ-008 SHALL have port pix_i  in  PIX_W  pixel value (bin index).
REQ-009 SHALL have port pix_ready_o  out  1  block accepts pixel.
REQ-010 SHALL have port rd_valid_o  out  1  histogram read-out beat valid.
REQ-011 SHALL have port rd_ready_i  in  1  downstream accepts read-out beat.
REQ-012 SHALL have port rd_data_o  out  PIX_W+CNT_W  {bin index, bin count}, index in MSBs.
REQ-013 SHALL have port busy_o  out  1  high in any state other than IDLE.
REQ-014 SHALL have port done_o  out  1  one-cycle pulse at end of frame read-out.

Function
REQ-015 SHALL implement states IDLE, CLEAR, ACCUM, FLUSH, DRAIN.
REQ-016 IDLE: start_i=1 -> CLEAR next cycle; start_i in any other state SHALL be ignored.
REQ-017 CLEAR: write 0 to bins 0..NB-1, one per cycle, NB cycles, then -> ACCUM.
REQ-018 ACCUM: pix_ready_o=1; a pixel is accepted on a cycle with pix_valid_i=1 and pix_ready_o=1; sustained throughput one pixel/cycle.
REQ-019 Each accepted pixel SHALL increment bin[pix_i] exactly once, including back-to-back identical values (read-modify-write hazard forwarded, no stall).
REQ-020 Bin count SHALL saturate at 2^CNT_W-1; further hits leave it unchanged.
REQ-021 After the NUM_PIX-th accepted pixel, pix_ready_o SHALL drop on the next cycle -> FLUSH; pixels offered afterwards are not accepted.
REQ-022 FLUSH: wait until all pending increments are committed (at most 2 cycles), then -> DRAIN.
REQ-023 DRAIN: present bins 0..NB-1 in ascending order; rd_valid_o=1; beat transfers when rd_valid_o=1 and rd_ready_i=1.
REQ-024 While rd_valid_o=1 and rd_ready_i=0, rd_data_o SHALL hold stable.
REQ-025 On transfer of bin NB-1: rd_valid_o=0 next cycle, done_o=1 for exactly that cycle, state -> IDLE.
REQ-026 pix_ready_o SHALL be 0 outside ACCUM; rd_valid_o SHALL be 0 outside DRAIN.
REQ-027 Counters SHALL NOT be modified in DRAIN; a later frame always starts with CLEAR.

Reset
REQ-028 rst_i=1 SHALL force state IDLE, pix_ready_o=0, rd_valid_o=0, rd_data_o=0, busy_o=0, done_o=0, internal indices 0, from the next edge.
REQ-029 Reset mid-frame (any state) SHALL abort the frame without done_o; bin contents undefined until the next CLEAR.
REQ-030 rst_i SHALL take priority over start_i and all handshakes in the same cycle.

Verification (PIX_W=2, CNT_W=3, NUM_PIX=8 unless stated)
REQ-031 start_i pulse, pixels 0,1,1,2,3,3,3,3 continuous, rd_ready_i=1 -> read-out {0,1},{1,2},{2,1},{3,4}, then done_o single pulse.
REQ-032 Eight back-to-back pixels of value 2 -> bin2=7 (saturated), bins 0,1,3=0.
REQ-033 pix_valid_i toggling 1/0 every cycle, pixels all 1 -> bin1=7, pix_ready_o low one cycle after the 8th accept, 9th offered pixel ignored.
REQ-034 rd_ready_i low for 3 cycles while bin 1 presented -> rd_data_o holds {1,count} stable, no beat lost or duplicated.
REQ-035 rst_i asserted during ACCUM after 4 pixels -> all outputs 0 next cycle, no done_o; new start_i plus 8 pixels of 0 -> read-out {0,7},{1,0},{2,0},{3,0}.
REQ-036 Default parameters, 76800 pixels of 255 -> bin255=76800, all others 0, 256 read-out beats.
